// File: rtl/wb_classic_to_pipe_bridge.sv
// Wishbone classic initiator to Wishbone pipelined target bridge.
// One transfer in flight, stall-based request phase, registered outputs,
// optional bus timeout that turns a hung target into an error.
module wb_classic_to_pipe_bridge #(
   parameter int unsigned AW             = 32,
   parameter int unsigned DW             = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   // classic initiator side
   input  logic [AW-1:0]   s_adr,
   input  logic [DW-1:0]   s_dat_w,
   input  logic [DW/8-1:0] s_sel,
   input  logic            s_we,
   input  logic            s_cyc,
   input  logic            s_stb,
   output logic [DW-1:0]   s_dat_r,
   output logic            s_ack,
   output logic            s_err,
   // pipelined target side
   output logic [AW-1:0]   m_adr,
   output logic [DW-1:0]   m_dat_w,
   output logic [DW/8-1:0] m_sel,
   output logic            m_we,
   output logic            m_cyc,
   output logic            m_stb,
   input  logic            m_stall,
   input  logic [DW-1:0]   m_dat_r,
   input  logic            m_ack,
   input  logic            m_err
);

   localparam int unsigned SW = DW / 8;
   localparam int unsigned CW = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t          r_state,   w_state_nxt;
   logic [CW-1:0]   r_cnt,     w_cnt_nxt;
   logic [AW-1:0]   r_adr,     w_adr_nxt;
   logic [DW-1:0]   r_dat_w,   w_dat_w_nxt;
   logic [SW-1:0]   r_sel,     w_sel_nxt;
   logic            r_we,      w_we_nxt;
   logic            r_cyc,     w_cyc_nxt;
   logic            r_stb,     w_stb_nxt;
   logic [DW-1:0]   r_dat_r,   w_dat_r_nxt;
   logic            r_ack,     w_ack_nxt;
   logic            r_err,     w_err_nxt;
   logic [CW-1:0]   w_cnt_inc;
   logic            w_timeout;

   // Counter holds the number of cycles already spent in REQ/WAIT; saturates.
   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES));

   // Next-state and next-output decode; outputs follow the state being entered.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_adr_nxt   = r_adr;
      w_dat_w_nxt = r_dat_w;
      w_sel_nxt   = r_sel;
      w_we_nxt    = r_we;
      w_dat_r_nxt = r_dat_r;
      w_ack_nxt   = 1'b0;
      w_err_nxt   = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (s_cyc && s_stb) begin
               w_adr_nxt   = s_adr;
               w_dat_w_nxt = s_dat_w;
               w_sel_nxt   = s_sel;
               w_we_nxt    = s_we;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            w_cnt_nxt = w_cnt_inc;
            if (!s_cyc) begin
               w_state_nxt = ST_IDLE;
            end else if (w_timeout) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = ST_RESP;
            end else if (!m_stall) begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            w_cnt_nxt = w_cnt_inc;
            if (!s_cyc) begin
               w_state_nxt = ST_IDLE;
            end else if (m_err) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = ST_RESP;
            end else if (m_ack) begin
               w_ack_nxt   = 1'b1;
               w_dat_r_nxt = m_dat_r;
               w_state_nxt = ST_RESP;
            end else if (w_timeout) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_cyc_nxt = (w_state_nxt == ST_REQ) || (w_state_nxt == ST_WAIT);
      w_stb_nxt = (w_state_nxt == ST_REQ);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_adr   <= '0;
         r_dat_w <= '0;
         r_sel   <= '0;
         r_we    <= 1'b0;
         r_cyc   <= 1'b0;
         r_stb   <= 1'b0;
         r_dat_r <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_adr   <= w_adr_nxt;
         r_dat_w <= w_dat_w_nxt;
         r_sel   <= w_sel_nxt;
         r_we    <= w_we_nxt;
         r_cyc   <= w_cyc_nxt;
         r_stb   <= w_stb_nxt;
         r_dat_r <= w_dat_r_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign m_adr   = r_adr;
   assign m_dat_w = r_dat_w;
   assign m_sel   = r_sel;
   assign m_we    = r_we;
   assign m_cyc   = r_cyc;
   assign m_stb   = r_stb;
   assign s_dat_r = r_dat_r;
   assign s_ack   = r_ack;
   assign s_err   = r_err;

endmodule
